// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3-column shift register,
// emitting registered row-major windows for the downstream max-pooling stage.

module window_gen_3x3_col #(
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [2:0][DATA_W-1:0] d_i,
  output logic [2:0][DATA_W-1:0] q_o
);
  logic [2:0][DATA_W-1:0] col_q;

  always_ff @(posedge clk) begin
    if (rst)       col_q <= '0;
    else if (en_i) col_q <= d_i;
  end

  assign q_o = col_q;
endmodule

module window_gen_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out0,
  output logic signed [DATA_W-1:0] data_out1,
  output logic signed [DATA_W-1:0] data_out2,
  output logic signed [DATA_W-1:0] data_out3,
  output logic signed [DATA_W-1:0] data_out4,
  output logic signed [DATA_W-1:0] data_out5,
  output logic signed [DATA_W-1:0] data_out6,
  output logic signed [DATA_W-1:0] data_out7,
  output logic signed [DATA_W-1:0] data_out8,
  output logic                     frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [1:0]    PH_LAST  = 2'(STRIDE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    cph_q, cph_d, rph_q, rph_d;
  logic          col_end, row_end, emit;
  logic          valid_q, fdone_q;

  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];

  logic [2:0][DATA_W-1:0]      new_col;
  logic [2:0][2:0][DATA_W-1:0] wcol, wcol_in;  // [column][row], column 0 oldest
  logic [8:0][DATA_W-1:0]      win_d, win_q;

  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);

  // Phase counters track (c-2)%STRIDE and (r-2)%STRIDE without a divider.
  assign emit = valid_in && (col_q >= CW'(2)) && (row_q >= RW'(2)) &&
                (cph_q == 2'd0) && (rph_q == 2'd0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (valid_in) begin
      if (col_end) begin
        col_d = '0;
        cph_d = 2'd0;
        if (row_end) begin
          row_d = '0;
          rph_d = 2'd0;
        end else begin
          row_d = row_q + 1'b1;
          if (row_q >= RW'(2)) rph_d = (rph_q == PH_LAST) ? 2'd0 : rph_q + 2'd1;
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q >= CW'(2)) cph_d = (cph_q == PH_LAST) ? 2'd0 : cph_q + 2'd1;
      end
    end
  end

  // Column entering the window: top = row r-2, middle = row r-1, bottom = current pixel.
  assign new_col = {data_in, lb0_q[col_q], lb1_q[col_q]};
  assign wcol_in = {new_col, wcol[2], wcol[1]};

  for (genvar k = 0; k < 3; k++) begin : g_col
    window_gen_3x3_col #(.DATA_W(DATA_W)) u_col (
      .clk  (clk),
      .rst  (rst),
      .en_i (valid_in),
      .d_i  (wcol_in[k]),
      .q_o  (wcol[k])
    );
  end

  // The window is taken from the post-shift columns so it is ready on the accepting edge.
  always_comb begin
    win_d = win_q;
    if (emit) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3+0] = wcol[1][r];
        win_d[r*3+1] = wcol[2][r];
        win_d[r*3+2] = new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && valid_in) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= 2'd0;
      rph_q   <= 2'd0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      valid_q <= emit;
      fdone_q <= valid_in && col_end && row_end;
      win_q   <= win_d;
    end
  end

  assign valid_out  = valid_q;
  assign frame_done = fdone_q;
  assign data_out0  = win_q[0];
  assign data_out1  = win_q[1];
  assign data_out2  = win_q[2];
  assign data_out3  = win_q[3];
  assign data_out4  = win_q[4];
  assign data_out5  = win_q[5];
  assign data_out6  = win_q[6];
  assign data_out7  = win_q[7];
  assign data_out8  = win_q[8];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4/STRIDE1 and a 5x5/STRIDE2 instance checked every cycle
// against an image-array reference model, plus directed window-content checks.

module tb_window_gen_3x3;
  typedef logic [8:0][15:0] win_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] vin, vout, fd;
  logic [1:0][15:0] din;
  logic [1:0][8:0][15:0] dout;

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .STRIDE(1)) u4 (
    .clk(clk), .rst(rst), .valid_in(vin[0]), .data_in(din[0]), .valid_out(vout[0]),
    .data_out0(dout[0][0]), .data_out1(dout[0][1]), .data_out2(dout[0][2]),
    .data_out3(dout[0][3]), .data_out4(dout[0][4]), .data_out5(dout[0][5]),
    .data_out6(dout[0][6]), .data_out7(dout[0][7]), .data_out8(dout[0][8]),
    .frame_done(fd[0])
  );

  window_gen_3x3 #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u5 (
    .clk(clk), .rst(rst), .valid_in(vin[1]), .data_in(din[1]), .valid_out(vout[1]),
    .data_out0(dout[1][0]), .data_out1(dout[1][1]), .data_out2(dout[1][2]),
    .data_out3(dout[1][3]), .data_out4(dout[1][4]), .data_out5(dout[1][5]),
    .data_out6(dout[1][6]), .data_out7(dout[1][7]), .data_out8(dout[1][8]),
    .frame_done(fd[1])
  );

  // Reference model: the frame as a 2D array, windows read straight out of it.
  int   IW[2] = '{4, 5};
  int   IH[2] = '{4, 5};
  int   IS[2] = '{1, 2};
  int   mr[2], mc[2];
  logic [15:0] img[2][5][5];
  win_t ewin[2];
  bit   ev[2], efd[2], prevv[2];
  int   pulses[2], fdones[2];
  bit   gapmode;
  win_t got0[$], got1[$], t1win[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid_out[%0d]", k), 144'(vout[k]), 144'(ev[k]));
      chk($sformatf("frame_done[%0d]", k), 144'(fd[k]), 144'(efd[k]));
      chk($sformatf("window[%0d]", k), dout[k], ewin[k]);
      if (gapmode) chk($sformatf("no_b2b[%0d]", k), 144'(vout[k] && prevv[k]), 144'(0));
      if (vout[k]) begin
        pulses[k]++;
        if (k == 0) got0.push_back(dout[0]); else got1.push_back(dout[1]);
      end
      if (fd[k]) fdones[k]++;
      prevv[k] = vout[k];
    end
  endtask

  task automatic step(input bit v0, input logic [15:0] d0, input bit v1, input logic [15:0] d1);
    bit vv[2];
    logic [15:0] dd[2];
    int r, c;
    vv[0] = v0; vv[1] = v1; dd[0] = d0; dd[1] = d1;
    vin = {v1, v0};
    din[0] = d0;
    din[1] = d1;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      efd[k] = 1'b0;
      if (vv[k]) begin
        r = mr[k];
        c = mc[k];
        img[k][r][c] = dd[k];
        if (r >= 2 && c >= 2 && (r - 2) % IS[k] == 0 && (c - 2) % IS[k] == 0) begin
          ev[k] = 1'b1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              ewin[k][i*3+j] = img[k][r-2+i][c-2+j];
        end
        efd[k] = (r == IH[k] - 1) && (c == IW[k] - 1);
        c++;
        if (c == IW[k]) begin
          c = 0;
          r++;
          if (r == IH[k]) r = 0;
        end
        mr[k] = r;
        mc[k] = c;
      end
    end
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vin = 2'b00;
    din = '0;
    for (int k = 0; k < 2; k++) begin
      mr[k] = 0; mc[k] = 0; ewin[k] = '0; ev[k] = 1'b0; efd[k] = 1'b0;
      pulses[k] = 0; fdones[k] = 0; prevv[k] = 1'b0;
    end
    got0.delete();
    got1.delete();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 144'(vout[k]), 144'(0));
      chk($sformatf("rst_fdone[%0d]", k), 144'(fd[k]), 144'(0));
      chk($sformatf("rst_data[%0d]", k), dout[k], 144'(0));
    end
    rst = 1'b0;
  endtask

  task automatic chk_words(input string tag, input win_t w, input int e[9]);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s.w%0d", tag, i), 144'(w[i]), 144'(16'(e[i])));
  endtask

  task automatic chk_vs_t1(input string tag, input int base);
    for (int i = 0; i < 4; i++)
      if (base + i < got0.size()) chk($sformatf("%s.win%0d", tag, i), got0[base+i], t1win[i]);
      else chk($sformatf("%s.missing%0d", tag, i), 144'(got0.size()), 144'(base + 4));
  endtask

  int t1f[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int t1l[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int t2w[9] = '{2, 3, 4, 7, 8, 9, 12, 13, 14};

  initial begin
    gapmode = 1'b0;
    do_reset();

    // T1: 4x4 stride 1, pixels 0..15 back-to-back
    for (int p = 0; p < 16; p++) step(1'b1, 16'(p), 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    chk("t1_pulses", 144'(pulses[0]), 144'(4));
    chk("t1_fdones", 144'(fdones[0]), 144'(1));
    if (got0.size() == 4) begin
      chk_words("t1_first", got0[0], t1f);
      chk_words("t1_last", got0[3], t1l);
    end else chk("t1_count", 144'(got0.size()), 144'(4));
    for (int i = 0; i < 9; i++) t1win.push_back(win_t'(0));
    t1win.delete();
    foreach (got0[i]) t1win.push_back(got0[i]);

    // T2: 5x5 stride 2, pixels 0..24
    do_reset();
    for (int p = 0; p < 25; p++) step(1'b0, 16'h0, 1'b1, 16'(p));
    chk("t2_pulses", 144'(pulses[1]), 144'(4));
    chk("t2_fdones", 144'(fdones[1]), 144'(1));
    if (got1.size() == 4) chk_words("t2_win14", got1[1], t2w);
    else chk("t2_count", 144'(got1.size()), 144'(4));

    // T3: T1 stream with 3 idle cycles between pixels
    do_reset();
    gapmode = 1'b1;
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 16'(p), 1'b0, 16'h0);
      for (int g = 0; g < 3; g++) step(1'b0, 16'h0, 1'b0, 16'h0);
    end
    gapmode = 1'b0;
    chk("t3_pulses", 144'(pulses[0]), 144'(4));
    chk_vs_t1("t3", 0);

    // T4: signed extremes
    do_reset();
    for (int p = 0; p < 16; p++) step(1'b1, (p == 5) ? 16'h7FFF : 16'h8000, 1'b0, 16'h0);
    if (got0.size() >= 2) begin
      chk("t4_w1_d4", 144'(got0[0][4]), 144'(16'h7FFF));
      chk("t4_w2_d3", 144'(got0[1][3]), 144'(16'h7FFF));
      chk("t4_w1_d0", 144'(got0[0][0]), 144'(16'h8000));
    end else chk("t4_count", 144'(got0.size()), 144'(4));

    // T5: reset after pixel 9, then full restart
    do_reset();
    for (int p = 0; p < 10; p++) step(1'b1, 16'(p), 1'b0, 16'h0);
    chk("t5_pre_pulses", 144'(pulses[0]), 144'(0));
    do_reset();
    for (int p = 0; p < 16; p++) step(1'b1, 16'(p), 1'b0, 16'h0);
    chk("t5_pulses", 144'(pulses[0]), 144'(4));
    chk_vs_t1("t5", 0);

    // T6: two frames back-to-back
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 16; p++) step(1'b1, 16'(p), 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 16'h0);
    chk("t6_pulses", 144'(pulses[0]), 144'(8));
    chk("t6_fdones", 144'(fdones[0]), 144'(2));
    chk_vs_t1("t6_f0", 0);
    chk_vs_t1("t6_f1", 4);

    // Random data and random valid gaps on both instances across several frames
    do_reset();
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0, 16'($urandom));
    chk("rand_fdones0_nonzero", 144'(fdones[0] > 0), 144'(1));
    chk("rand_fdones1_nonzero", 144'(fdones[1] > 0), 144'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
